vga_sync_monitor: RTL
=====================

VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 SHALL have parameter H_MAX, default 10'd1023, the saturation value of every pixel-tick counter.
REQ-002 SHALL have parameter V_MAX, default 10'd1023, the saturation value of every line counter.
REQ-003 SHALL have port Clk, input, 1, 50 MHz system clock; all logic on rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port pixel_clk, input, 1, 25 MHz pixel clock from the sync generator, sampled as data.
REQ-006 SHALL have port hs, input, 1, horizontal sync, active low.
REQ-007 SHALL have port vs, input, 1, vertical sync, active low.
REQ-008 SHALL have port blank, input, 1, display-enable, high = visible pixel.
REQ-009 SHALL have port RecX, output, 10, recovered horizontal pixel coordinate.
REQ-010 SHALL have port RecY, output, 10, recovered vertical line coordinate.
REQ-011 SHALL have port active, output, 1, RecX/RecY valid for the current visible pixel.
REQ-012 SHALL have port line_len, output, 10, ticks between the last two hs falling edges.
REQ-013 SHALL have port hs_width, output, 10, ticks hs was low in the last pulse.
REQ-014 SHALL have port frame_lines, output, 10, lines between the last two vs falling edges.
REQ-015 SHALL have port vs_width, output, 10, lines vs was low in the last pulse.
REQ-016 SHALL have port locked, output, 1, timing stable and matching reference.
REQ-017 SHALL have port timing_err, output, 1, one-Clk pulse on loss of lock.

Function
REQ-018 SHALL register pixel_clk, hs, vs and blank once in Clk; tick = registered pixel_clk rising edge; all state below advances only on tick.
REQ-019 SHALL detect hs/vs falling edges and blank rising edges by comparing current against previous tick-sampled values.
REQ-020 SHALL count ticks per line; on hs fall load line_len = count (nominal 800) and restart the count at 1.
REQ-021 SHALL count hs-low ticks and load hs_width on hs rising edge (nominal 96).
REQ-022 SHALL count lines (hs falls) per frame; on vs fall load frame_lines (nominal 525); vs_width = hs falls while vs low (nominal 2).
REQ-023 SHALL saturate all counters at H_MAX/V_MAX; a saturated capture is a mismatch.
REQ-024 SHALL set RecX = 0 on blank rising edge and increment it on each tick with blank high.
REQ-025 SHALL set RecY = 0 on the first blank rising edge after vs fall, and increment it on each later blank rising edge.
REQ-026 SHALL drive active = blank_sampled & locked.
REQ-027 SHALL implement FSM SEARCH -> MEASURE on vs fall; MEASURE -> VERIFY on next vs fall, latching line_len/frame_lines as references.
REQ-028 SHALL move VERIFY -> LOCKED on next vs fall if both captures equal references, else stay VERIFY with new references.
REQ-029 SHALL move LOCKED -> SEARCH on any hs-fall line_len or vs-fall frame_lines mismatch, pulsing timing_err for one Clk.
REQ-030 SHALL process hs fall and vs fall occurring on the same tick in one update: line capture first, then frame capture.
REQ-031 SHALL hold all state when no tick occurs (pixel_clk stalled).

Reset
REQ-032 SHALL on Reset clear all counters, RecX, RecY, line_len, hs_width, frame_lines, vs_width, references to 0, and locked, active, timing_err to 0.
REQ-033 SHALL reset the FSM to SEARCH and sampled hs/vs/blank registers to 1, pixel_clk register to 0; Reset mid-frame forces re-acquisition.

Configuration
REQ-034 SHALL, with VGA_SYNC_MON_ERRCNT_EN defined, add output err_count[7:0], incremented on each timing_err pulse, saturating at 255, cleared by Reset.
REQ-035 SHALL, without VGA_SYNC_MON_ERRCNT_EN, omit err_count port and logic entirely.

Verification
REQ-036 SHALL cover: nominal 800x525 generator from reset -> locked rises after third vs fall; line_len=800, hs_width=96, frame_lines=525, vs_width=2.
REQ-037 SHALL cover: locked, first visible pixel -> RecX=0, RecY=0, active=1; last visible pixel -> RecX=639, RecY=479.
REQ-038 SHALL cover: one line stretched to 801 ticks while locked -> timing_err one-Clk pulse, locked=0, FSM in SEARCH, relock after three vs falls.
REQ-039 SHALL cover: pixel_clk held low 1000 Clk while locked -> no output changes; Reset asserted mid-frame -> all outputs 0 next Clk.
REQ-040 SHALL cover: with VGA_SYNC_MON_ERRCNT_EN, 300 forced mismatches -> err_count=255.

Source files
------------

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers pixel coordinates from a VGA sync stream, measures
// hs/vs timing and locks once it repeats. Define VGA_SYNC_MON_ERRCNT_EN for err_count.
//
// state   | meaning
// SEARCH  | idle, waiting for a vs fall to begin acquisition
// MEASURE | first (possibly partial) frame, captures still settling
// VERIFY  | references held, next frame must reproduce them
// LOCKED  | every line and frame matches the references
module vga_sync_monitor #(
   parameter logic [9:0] H_MAX = 10'd1023,
   parameter logic [9:0] V_MAX = 10'd1023
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       pixel_clk,
   input  logic       hs,
   input  logic       vs,
   input  logic       blank,
   output logic [9:0] RecX,
   output logic [9:0] RecY,
   output logic       active,
   output logic [9:0] line_len,
   output logic [9:0] hs_width,
   output logic [9:0] frame_lines,
   output logic [9:0] vs_width,
   output logic       locked,
`ifdef VGA_SYNC_MON_ERRCNT_EN
   output logic       timing_err,
   output logic [7:0] err_count
`else
   output logic       timing_err
`endif
);

   typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;
   state_t state, state_nxt;

   logic       pclk_s, pclk_d, hs_s, vs_s, blank_s;
   logic       hs_t, vs_t, blank_t;
   logic       tick, hs_fall, hs_rise, vs_fall, vs_rise, blank_rise;
   logic [9:0] h_cnt, hs_low_cnt, v_cnt, vs_low_cnt;
   logic [9:0] ref_line, ref_frame, v_cnt_inc, line_now, frame_now;
   logic       y_first, line_ok, frame_ok, line_bad, load_ref, err_fire;

   function automatic logic [9:0] sat_inc(input logic [9:0] val, input logic [9:0] lim);
      return (val >= lim) ? lim : val + 10'd1;
   endfunction

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pclk_s  <= 1'b0;
         pclk_d  <= 1'b0;
         hs_s    <= 1'b1;
         vs_s    <= 1'b1;
         blank_s <= 1'b1;
      end else begin
         pclk_s  <= pixel_clk;
         pclk_d  <= pclk_s;
         hs_s    <= hs;
         vs_s    <= vs;
         blank_s <= blank;
      end
   end

   assign tick       = pclk_s & ~pclk_d;
   assign hs_fall    = tick & hs_t & ~hs_s;
   assign hs_rise    = tick & ~hs_t & hs_s;
   assign vs_fall    = tick & vs_t & ~vs_s;
   assign vs_rise    = tick & ~vs_t & vs_s;
   assign blank_rise = tick & ~blank_t & blank_s;

   // A coincident hs fall is folded in before the frame capture sees the counts.
   assign v_cnt_inc = hs_fall ? sat_inc(v_cnt, V_MAX) : v_cnt;
   assign line_now  = hs_fall ? h_cnt : line_len;
   assign frame_now = v_cnt_inc;
   assign line_ok   = (line_now == ref_line) && (line_now != H_MAX);
   assign frame_ok  = (frame_now == ref_frame) && (frame_now != V_MAX);
   assign line_bad  = (h_cnt != ref_line) || (h_cnt == H_MAX);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hs_t        <= 1'b1;
         vs_t        <= 1'b1;
         blank_t     <= 1'b1;
         h_cnt       <= '0;
         hs_low_cnt  <= '0;
         v_cnt       <= '0;
         vs_low_cnt  <= '0;
         line_len    <= '0;
         hs_width    <= '0;
         frame_lines <= '0;
         vs_width    <= '0;
         RecX        <= '0;
         RecY        <= '0;
         y_first     <= 1'b0;
         ref_line    <= '0;
         ref_frame   <= '0;
      end else if (tick) begin
         hs_t    <= hs_s;
         vs_t    <= vs_s;
         blank_t <= blank_s;

         if (hs_fall) begin
            line_len <= h_cnt;
            h_cnt    <= 10'd1;
         end else begin
            h_cnt <= sat_inc(h_cnt, H_MAX);
         end

         if (!hs_s)
            hs_low_cnt <= hs_fall ? 10'd1 : sat_inc(hs_low_cnt, H_MAX);
         if (hs_rise)
            hs_width <= hs_low_cnt;

         if (vs_fall) begin
            frame_lines <= v_cnt_inc;
            v_cnt       <= '0;
            vs_low_cnt  <= hs_fall ? 10'd1 : 10'd0;
         end else begin
            v_cnt <= v_cnt_inc;
            if (!vs_s && hs_fall)
               vs_low_cnt <= sat_inc(vs_low_cnt, V_MAX);
         end
         if (vs_rise)
            vs_width <= vs_low_cnt;

         if (blank_rise)
            RecX <= '0;
         else if (blank_s)
            RecX <= sat_inc(RecX, H_MAX);

         // RecY restarts on the first visible line after vs falls.
         if (blank_rise) begin
            RecY    <= (y_first || vs_fall) ? 10'd0 : sat_inc(RecY, V_MAX);
            y_first <= 1'b0;
         end else if (vs_fall) begin
            y_first <= 1'b1;
         end

         if (load_ref) begin
            ref_line  <= line_now;
            ref_frame <= frame_now;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         state <= SEARCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_ref  = 1'b0;
      err_fire  = 1'b0;
      case (state)
         SEARCH:
            if (vs_fall)
               state_nxt = MEASURE;
         MEASURE:
            if (vs_fall) begin
               state_nxt = VERIFY;
               load_ref  = 1'b1;
            end
         VERIFY:
            if (vs_fall) begin
               if (line_ok && frame_ok)
                  state_nxt = LOCKED;
               else
                  load_ref = 1'b1;
            end
         LOCKED:
            if ((hs_fall && line_bad) || (vs_fall && !frame_ok)) begin
               state_nxt = SEARCH;
               err_fire  = 1'b1;
            end
         default:
            state_nxt = SEARCH;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         timing_err <= 1'b0;
      else
         timing_err <= err_fire;
   end

`ifdef VGA_SYNC_MON_ERRCNT_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         err_count <= '0;
      else if (err_fire && (err_count != 8'hFF))
         err_count <= err_count + 8'd1;
   end
`endif

   assign locked = (state == LOCKED);
   assign active = blank_t & locked;

endmodule
